// File: rtl/fetch_prefetch_unit_pkg.sv
// fetch_prefetch_unit_pkg: shared widths and front-end state encoding
package fetch_prefetch_unit_pkg;
    localparam int IW = 16;
    localparam int PW = 16;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} fe_state_t;
endpackage

// File: rtl/fetch_prefetch_unit_prefetch_fifo.sv
// prefetch_fifo: DEPTH-entry queue of {pc, instr} pairs with push/pop/clear
// ports: clk, rst (async active-low), push/wdata, pop, clear, rdata (head), count
module prefetch_fifo
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int W = PW + IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rp;
    logic [AW-1:0] wp;
    // storage is cleared on reset so the head reads as zero until the first push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '{default: '0};
            rp <= '0;
            wp <= '0;
            count <= '0;
        end else if (clear) begin
            rp <= '0;
            wp <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= wdata;
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    assign rdata = mem[rp];
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC owner, imem request issue and prefetch queue feeding IF/ID
// ports: clk, rst (async active-low); imem_req/imem_addr/imem_rdata to the synchronous
// instruction memory; if_valid/if_ready/if_instr/if_pc/if_pc_plus1 to IF/ID;
// redirect/redirect_pc from downstream; halt in, done out; fetch_count of delivered instructions
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [PW-1:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [PW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [IW-1:0] if_instr,
    output logic [PW-1:0] if_pc,
    output logic [PW-1:0] if_pc_plus1,
    input  logic          redirect,
    input  logic [PW-1:0] redirect_pc,
    input  logic          halt,
    output logic          done,
    output logic [31:0]   fetch_count
);
    localparam int AW = $clog2(DEPTH);
    fe_state_t state;
    fe_state_t state_nx;
    logic [PW-1:0] fetch_pc;
    logic [PW-1:0] tag_pc;
    logic epoch;
    logic tag_epoch;
    logic inflight;
    logic flush;
    logic pop;
    logic push;
    logic [AW:0] count;
    logic [AW:0] occ;
    logic [PW+IW-1:0] head;
    assign flush = redirect && state != HALTED;
    assign if_valid = count != '0 && state != HALTED;
    assign pop = if_valid && if_ready && !flush;
    assign push = inflight && tag_epoch == epoch && !flush;
    // credit: entries held plus the read in flight, net of this cycle's pop
    assign occ = count + (AW+1)'(inflight) - (AW+1)'(pop);
    // gating with rst keeps the request low throughout asynchronous reset
    assign imem_req = rst && state == RUN && !halt && !flush && occ < (AW+1)'(DEPTH);
    assign imem_addr = fetch_pc;
    assign {if_pc, if_instr} = head;
    assign if_pc_plus1 = if_pc + 1'b1;
    assign done = state == HALTED;
    always_comb begin
        state_nx = state;
        state_nx = (state == RUN && halt) ? DRAIN
                 : (state == DRAIN && count == '0 && !inflight) ? HALTED
                 : state;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            fetch_pc <= RESET_PC;
            epoch <= 1'b0;
            inflight <= 1'b0;
            tag_pc <= '0;
            tag_epoch <= 1'b0;
            fetch_count <= '0;
        end else begin
            state <= state_nx;
            fetch_pc <= flush ? redirect_pc : imem_req ? fetch_pc + 1'b1 : fetch_pc;
            epoch <= epoch ^ flush;
            inflight <= imem_req;
            tag_pc <= fetch_pc;
            tag_epoch <= epoch;
            fetch_count <= fetch_count + 32'(pop);
        end
    end
    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata ({tag_pc, imem_rdata}),
        .rdata (head),
        .count (count)
    );
endmodule
